// File: rtl/alu_seq_divider.sv
// alu_seq_divider
// ---------------------------------------------------------------------------
// Iterative restoring divider that sits beside the combinational add/sub unit
// and provides UDIV/SDIV. One quotient bit is resolved per clock. Results are
// held on q/r until the next accepted operation completes.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request, sampled only while idle
//   sign   - 1 = signed (SDIV), 0 = unsigned (UDIV), sampled with start
//   a      - dividend, sampled with start
//   b      - divisor, sampled with start
//   q      - quotient (registered)
//   r      - remainder (registered)
//   busy   - high while an operation is in flight (LOAD/RUN/FIX)
//   done   - one-cycle pulse, q/r valid from this cycle
//
// Optional build macro:
//   ALU_DIV_EARLY_OUT_EN - when defined, the iteration counter is preset to
//   skip the leading zero bits of the dividend magnitude, and a zero dividend
//   magnitude goes straight to FIX. Without it every non-zero divisor takes a
//   fixed WIDTH+2 clocks and no leading-zero logic is built.
// ---------------------------------------------------------------------------
module alu_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIX
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_partRem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_qOut;
  logic [WIDTH-1:0] r_rOut;
  logic             r_sign;
  logic             r_qNeg;
  logic             r_rNeg;
  logic             r_done;
  logic [CW-1:0]    r_count;

  logic [WIDTH-1:0] w_aMag;
  logic [WIDTH-1:0] w_bMag;
  logic             w_aNeg;
  logic             w_bNeg;
  logic             w_divZero;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_diff;
  logic             w_noBorrow;
  logic [CW-1:0]    w_preset;

  // While in LOAD the operand registers still hold the raw inputs, so these
  // give the operand signs and magnitudes. A min_int magnitude is exactly
  // 2^(WIDTH-1) as an unsigned value, which the datapath handles naturally.
  assign w_aNeg    = r_sign & r_dividend[WIDTH-1];
  assign w_bNeg    = r_sign & r_divisor[WIDTH-1];
  assign w_aMag    = w_aNeg ? (~r_dividend + WIDTH'(1)) : r_dividend;
  assign w_bMag    = w_bNeg ? (~r_divisor + WIDTH'(1)) : r_divisor;
  assign w_divZero = (r_divisor == '0);

  // Trial subtract on the widened partial remainder, using the same
  // a + ~b + 1 form as the adder. The stored remainder is always below the
  // divisor magnitude, so the shifted value is below twice the divisor and
  // the difference always fits in WIDTH+1 signed bits: its top bit is the
  // borrow.
  assign w_shifted  = {r_partRem, r_dividend[r_count]};
  assign w_diff     = w_shifted + ~{1'b0, r_divisor} + (WIDTH + 1)'(1);
  assign w_noBorrow = ~w_diff[WIDTH];

`ifdef ALU_DIV_EARLY_OUT_EN
  logic          w_aZero;
  logic [CW-1:0] w_lead;

  // Index of the highest set bit of the dividend magnitude. Bits above it
  // would only shift zeros into the remainder and zeros into the quotient,
  // so the iteration starts there instead of at the top.
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_aMag[i]) w_lead = CW'(i);
    end
  end

  assign w_aZero  = (w_aMag == '0);
  assign w_preset = w_lead;
`else
  assign w_preset = CW'(WIDTH - 1);
`endif

  // State register. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. A zero divisor has nothing to iterate over, so LOAD
  // skips RUN and lets FIX produce q=0, r=a.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_nextState = LOAD;
      end
      LOAD: begin
        if (w_divZero) begin
          w_nextState = FIX;
`ifdef ALU_DIV_EARLY_OUT_EN
        end else if (w_aZero) begin
          w_nextState = FIX;
`endif
        end else begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (r_count == '0) w_nextState = FIX;
      end
      FIX: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output decode. busy covers LOAD/RUN/FIX, so it falls on the same edge
  // that raises done.
  always_comb begin
    busy = (r_state != IDLE);
    done = r_done;
    q    = r_qOut;
    r    = r_rOut;
  end

  // Iteration datapath. IDLE captures the raw operands, LOAD converts them
  // to magnitudes in place and records the result signs, RUN resolves one
  // quotient bit per clock MSB first. For a zero divisor the remainder is
  // seeded with |a| so that FIX restores the dividend's sign and returns a.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_sign     <= 1'b0;
      r_qNeg     <= 1'b0;
      r_rNeg     <= 1'b0;
      r_partRem  <= '0;
      r_quot     <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dividend <= a;
            r_divisor  <= b;
            r_sign     <= sign;
          end
        end
        LOAD: begin
          r_dividend <= w_aMag;
          r_divisor  <= w_bMag;
          r_qNeg     <= w_aNeg ^ w_bNeg;
          r_rNeg     <= w_aNeg;
          r_quot     <= '0;
          r_partRem  <= w_divZero ? w_aMag : '0;
          r_count    <= w_preset;
        end
        RUN: begin
          r_partRem <= w_noBorrow ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
          r_quot    <= {r_quot[WIDTH-2:0], w_noBorrow};
          if (r_count != '0) r_count <= r_count - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers. They only change in FIX, where the signs are applied
  // and done is pulsed; otherwise they hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qOut <= '0;
      r_rOut <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      if (r_state == FIX) begin
        r_qOut <= r_qNeg ? (~r_quot + WIDTH'(1)) : r_quot;
        r_rOut <= r_rNeg ? (~r_partRem + WIDTH'(1)) : r_partRem;
      end
    end
  end

endmodule
